// File: rtl/digital_input_conditioner.sv
// Input conditioner for one raw external pin. It synchronizes the pin, applies optional
// inversion, and qualifies edges with a programmable glitch filter. It outputs the clean
// level, edge strobes, a committed-rise counter and a rejected-glitch counter.
module digital_input_conditioner #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned FILTER_WIDTH = 16
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    signal_in,
  input  logic                    invert_in,
  input  logic [FILTER_WIDTH-1:0] filter_len_in,
  input  logic                    count_clear_in,
  output logic                    signal_out,
  output logic                    rise_out,
  output logic                    fall_out,
  output logic [31:0]             edge_count_out,
  output logic [15:0]             glitch_count_out
);

  typedef enum logic [1:0] {
    StStableLow,
    StQualHigh,
    StStableHigh,
    StQualLow
  } state_e;

  state_e                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic [FILTER_WIDTH-1:0] cnt_q, cnt_d;
  logic                    signal_q, signal_d;
  logic                    rise_q, rise_d;
  logic                    fall_q, fall_d;
  logic [31:0]             edge_count_q, edge_count_d;
  logic [15:0]             glitch_count_q, glitch_count_d;

  logic                    s;
  logic                    bypass;
  logic                    qualified;
  logic                    glitch_evt;
  logic [FILTER_WIDTH-1:0] cnt_inc;

  // Synchronizer shift, filtered-level selection and the saturating qualification step
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], signal_in};
    s         = sync_q[SYNC_STAGES-1] ^ invert_in;
    bypass    = (filter_len_in == '0);
    // filter_len_in is compared live, so a lowered length commits on the next edge
    qualified = (cnt_q >= filter_len_in);
    cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + FILTER_WIDTH'(1);
  end

  // State register: synchronizer, FSM, qualification counter, outputs and counters
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync_q         <= '0;
      state_q        <= StStableLow;
      cnt_q          <= '0;
      signal_q       <= 1'b0;
      rise_q         <= 1'b0;
      fall_q         <= 1'b0;
      edge_count_q   <= '0;
      glitch_count_q <= '0;
    end else begin
      sync_q         <= sync_d;
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      signal_q       <= signal_d;
      rise_q         <= rise_d;
      fall_q         <= fall_d;
      edge_count_q   <= edge_count_d;
      glitch_count_q <= glitch_count_d;
    end
  end

  // Next-state logic: qualify an excursion, or track s directly when the filter is bypassed
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bypass) begin
      state_d = s ? StStableHigh : StStableLow;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StStableLow: begin
          if (s) begin
            state_d = StQualHigh;
            cnt_d   = FILTER_WIDTH'(1);
          end else begin
            cnt_d = '0;
          end
        end
        StQualHigh: begin
          if (!s) begin
            state_d = StStableLow;
            cnt_d   = '0;
          end else if (qualified) begin
            state_d = StStableHigh;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        StStableHigh: begin
          if (!s) begin
            state_d = StQualLow;
            cnt_d   = FILTER_WIDTH'(1);
          end else begin
            cnt_d = '0;
          end
        end
        StQualLow: begin
          if (s) begin
            state_d = StStableHigh;
            cnt_d   = '0;
          end else if (qualified) begin
            state_d = StStableLow;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = StStableLow;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output logic: level commit, one-cycle strobes and glitch events
  always_comb begin
    signal_d   = signal_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    glitch_evt = 1'b0;
    if (bypass) begin
      signal_d = s;
      rise_d   = s & ~signal_q;
      fall_d   = ~s & signal_q;
    end else begin
      case (state_q)
        StQualHigh: begin
          if (!s) begin
            glitch_evt = 1'b1;
          end else if (qualified) begin
            signal_d = 1'b1;
            rise_d   = 1'b1;
          end
        end
        StQualLow: begin
          if (s) begin
            glitch_evt = 1'b1;
          end else if (qualified) begin
            signal_d = 1'b0;
            fall_d   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Event counters; a clear coinciding with an event leaves the count at 1
  always_comb begin
    if (count_clear_in) begin
      edge_count_d = 32'(rise_d);
    end else begin
      edge_count_d = edge_count_q + 32'(rise_d);
    end

    if (count_clear_in) begin
      glitch_count_d = 16'(glitch_evt);
    end else if (glitch_evt && (glitch_count_q != 16'hFFFF)) begin
      glitch_count_d = glitch_count_q + 16'd1;
    end else begin
      glitch_count_d = glitch_count_q;
    end
  end

  assign signal_out       = signal_q;
  assign rise_out         = rise_q;
  assign fall_out         = fall_q;
  assign edge_count_out   = edge_count_q;
  assign glitch_count_out = glitch_count_q;

endmodule

// File: doc/digital_input_conditioner.md
# digital_input_conditioner

Conditions one raw external digital input before it enters the delay and servo logic. The block synchronizes the asynchronous pin, applies optional polarity inversion, and rejects glitches shorter than a programmable qualification length. It outputs the clean level, single-cycle edge strobes, a committed-rising-edge counter and a rejected-glitch counter. Its signal_out drives the signal_in of the downstream edge-delay stage.

## Interface
- SYNC_STAGES, 2, number of flip-flops in the input synchronizer (≥2)
- FILTER_WIDTH, 16, width of filter_len_in and of the qualification counter
- clk_in  input  1  system clock
- rst_in  input  1  reset, asynchronous, active-high
- signal_in  input  1  raw asynchronous input pin
- invert_in  input  1  1 = invert synchronized input before filtering
- filter_len_in  input  FILTER_WIDTH  qualification length L in cycles; 0 = bypass filter
- count_clear_in  input  1  synchronous clear of both counters
- signal_out  output  1  conditioned level
- rise_out  output  1  one-cycle strobe on committed 0→1
- fall_out  output  1  one-cycle strobe on committed 1→0
- edge_count_out  output  32  committed rising edges, wrapping
- glitch_count_out  output  16  rejected pulses, saturating

## Operation
- Reset: sync chain, state, qualification counter, signal_out, rise_out, fall_out, edge_count_out, glitch_count_out all 0; state STABLE_LOW.
- s = (last sync stage) XOR invert_in (combinational).
- FSM states: STABLE_LOW, QUAL_HIGH, STABLE_HIGH, QUAL_LOW.
  - STABLE_LOW: s=1 → QUAL_HIGH, cnt←1; else stay, cnt←0.
  - QUAL_HIGH: s=0 → STABLE_LOW, glitch event; else cnt≥L → STABLE_HIGH, signal_out←1, rise_out←1; else cnt←cnt+1.
  - STABLE_HIGH / QUAL_LOW: mirror of the above, with fall_out on commit.
- Bypass (L=0): signal_out←s every cycle, rise_out/fall_out follow the changes, no glitch events. The FSM is forced to STABLE_LOW or STABLE_HIGH to match s, with cnt←0.
- L is compared live. Lowering L during qualification so that cnt≥L commits on the next cycle. Raising L extends qualification.
- cnt saturates at 2^FILTER_WIDTH−1, so it never wraps.
- A change of invert_in appears as an edge on s and is filtered like any other edge.
- edge_count_out increments on each rise_out and wraps 0xFFFFFFFF→0.
- glitch_count_out increments on each glitch event and holds at 0xFFFF.
- count_clear_in: the counter is loaded with 0, or with 1 if an increment event occurs in the same cycle. The clear does not affect signal_out or the FSM.
- If the input is high when reset is released, it qualifies normally and produces a rise_out that is counted.

## Timing
- Synchronizer: signal_in sampled at edge k is visible on s after edge k+SYNC_STAGES−1.
- Filtered (L≥1): s held stable from cycle t → signal_out changes at edge t+L+1. Total pin→signal_out latency = SYNC_STAGES+L+1 cycles.
- Bypass: pin→signal_out latency = SYNC_STAGES+1 cycles.
- rise_out/fall_out are asserted for exactly the one cycle in which signal_out first shows the new level.
- Counters update on the same edge that raises the strobe.
- Rejection: any s excursion lasting ≤L cycles is rejected (no output change, glitch +1). An excursion of ≥L+1 cycles commits.
- rst_in assertion mid-qualification immediately returns everything to reset values. No strobe is emitted.

## Test plan
- L=4, invert=0: pin held high for 20 cycles → signal_out rises SYNC_STAGES+5 cycles after the pin edge; rise_out high for one cycle; edge_count_out=1; glitch_count_out=0.
- L=4: pin high pulses of 3 and 4 cycles → no output change; glitch_count_out=2. Then a 5-cycle pulse → single rise/fall; edge_count_out=1.
- L=0: 1-cycle pin pulse → signal_out pulses 1 cycle, SYNC_STAGES+1 cycles late; glitch_count_out=0.
- invert_in toggled 0→1 with pin low, L=2 → signal_out rises after 3 cycles; rise_out asserted.
- Preload edge_count_out to 0xFFFFFFFF → next rise gives 0. Force 70000 glitches → glitch_count_out holds 0xFFFF. count_clear_in coincident with a rise → edge_count_out=1.
- L=10, assert rst_in at cnt=6 → all outputs 0 immediately. After release with pin high → rise at SYNC_STAGES+11 cycles.
